// File: rtl/fixed_point_mac_accumulator.sv
// Streaming accumulate/requantize stage for fixed_point_multiplication products.
// Sums a packet in a guard-bit accumulator, then rounds and saturates on last.
module fixed_point_mac_accumulator #(
    parameter int N1    = 8,
    parameter int N2    = 8,
    parameter int M1    = 8,
    parameter int M2    = 8,
    parameter int G     = 8,
    parameter int N_OUT = 8,
    parameter int M_OUT = 8,
    parameter int CW    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N1+N2+M1+M2-1:0]        in_product,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_OUT+M_OUT-1:0]        out_result,
    output logic                          out_sat,
    output logic [CW-1:0]                 out_count
);
    localparam int PW = N1 + N2 + M1 + M2;
    localparam int AW = PW + G;
    localparam int OW = N_OUT + M_OUT;
    localparam int SH = M1 + M2 - M_OUT;

    localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
    localparam logic [OW-1:0] OUT_MAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0] OUT_MIN = {1'b1, {(OW-1){1'b0}}};
    localparam logic [AW:0]   HALF    = (AW+1)'(1) << (SH-1);

    typedef enum logic [1:0] {
        ACCUM,
        ROUND,
        OUTPUT
    } state_t;

    state_t               state_q;
    logic [AW-1:0]        acc_q;
    logic [AW-1:0]        acc_d;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic                 ovf_q;
    logic                 ovf_d;
    logic [AW:0]          sum_d;
    logic signed [AW:0]   half_sum_d;
    logic signed [AW:0]   rnd_d;
    logic [OW-1:0]        res_d;
    logic                 sat_d;

    assign in_ready  = (state_q == ACCUM) && !rst;
    assign out_valid = (state_q == OUTPUT);

    // Saturating accumulate of the incoming product and saturating beat count
    always_comb begin
        sum_d = {acc_q[AW-1], acc_q}
              + {{(G+1){in_product[PW-1]}}, in_product};
        acc_d = sum_d[AW-1:0];
        ovf_d = ovf_q;
        if (sum_d[AW] != sum_d[AW-1]) begin
            acc_d = sum_d[AW] ? ACC_MIN : ACC_MAX;
            ovf_d = 1'b1;
        end
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end

    // Round half up at AW+1 bits, then clamp into the output range
    always_comb begin
        half_sum_d = $signed({acc_q[AW-1], acc_q} + HALF);
        rnd_d      = half_sum_d >>> SH;
        res_d      = rnd_d[OW-1:0];
        sat_d      = 1'b0;
        if (!rnd_d[AW] && (|rnd_d[AW-1:OW-1])) begin
            res_d = OUT_MAX;
            sat_d = 1'b1;
        end else if (rnd_d[AW] && !(&rnd_d[AW-1:OW-1])) begin
            res_d = OUT_MIN;
            sat_d = 1'b1;
        end
    end

    // Packet FSM: accumulate, round for one cycle, hold result until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            out_result <= '0;
            out_sat    <= 1'b0;
            out_count  <= '0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (in_valid && in_ready) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        ovf_q <= ovf_d;
                        if (in_last) begin
                            state_q <= ROUND;
                        end
                    end
                end
                ROUND: begin
                    out_result <= res_d;
                    out_sat    <= ovf_q | sat_d;
                    out_count  <= cnt_q;
                    state_q    <= OUTPUT;
                end
                OUTPUT: begin
                    if (out_ready) begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= ACCUM;
                    end
                end
                default: begin
                    state_q <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_mac_accumulator.sv
// Directed bench for fixed_point_mac_accumulator: default build plus a G=1 build.
// Expected results are queued when a packet is driven and popped on output.
module tb_fixed_point_mac_accumulator;

    typedef struct packed {
        logic [15:0] res;
        logic        sat;
        logic [7:0]  cnt;
    } exp_t;

    logic        clk;
    logic        rst        [2];
    logic        in_valid   [2];
    logic        in_ready   [2];
    logic [31:0] in_product [2];
    logic        in_last    [2];
    logic        out_valid  [2];
    logic        out_ready  [2];
    logic [15:0] out_result [2];
    logic        out_sat    [2];
    logic [7:0]  out_count  [2];

    exp_t        sb [$];
    logic [31:0] pk [$];
    int          checks   = 0;
    int          failures = 0;
    int          stalls;

    logic [31:0] t_in  [7];
    logic [15:0] t_out [7];
    logic        t_sat [7];

    fixed_point_mac_accumulator u_dut0 (
        .clk        (clk),
        .rst        (rst[0]),
        .in_valid   (in_valid[0]),
        .in_ready   (in_ready[0]),
        .in_product (in_product[0]),
        .in_last    (in_last[0]),
        .out_valid  (out_valid[0]),
        .out_ready  (out_ready[0]),
        .out_result (out_result[0]),
        .out_sat    (out_sat[0]),
        .out_count  (out_count[0])
    );

    fixed_point_mac_accumulator #(.G(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst[1]),
        .in_valid   (in_valid[1]),
        .in_ready   (in_ready[1]),
        .in_product (in_product[1]),
        .in_last    (in_last[1]),
        .out_valid  (out_valid[1]),
        .out_ready  (out_ready[1]),
        .out_result (out_result[1]),
        .out_sat    (out_sat[1]),
        .out_count  (out_count[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int s, input logic [31:0] b [$],
                        input logic last_end, input logic push,
                        input logic [15:0] er, input logic es);
        int n;
        exp_t e;
        stalls = 0;
        for (int i = 0; i < b.size(); i++) begin
            in_valid[s]   = 1'b1;
            in_product[s] = b[i];
            in_last[s]    = last_end && (i == b.size() - 1);
            n = 0;
            while (in_ready[s] !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
                stalls++;
            end
            if (n >= 50) chk("in_ready_timeout", 32'(in_ready[s]), 32'd1);
            @(negedge clk);
        end
        in_valid[s] = 1'b0;
        in_last[s]  = 1'b0;
        if (push) begin
            e.res = er;
            e.sat = es;
            e.cnt = 8'(b.size());
            sb.push_back(e);
        end
    endtask

    task automatic collect(input int s, input int lat);
        int   n;
        exp_t e;
        n = 0;
        while (out_valid[s] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_rise", 32'(out_valid[s]), 32'd1);
        if (lat >= 0) chk("latency", n, lat);
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        chk("out_result", 32'(out_result[s]), 32'(e.res));
        chk("out_sat", 32'(out_sat[s]), 32'(e.sat));
        chk("out_count", 32'(out_count[s]), 32'(e.cnt));
        out_ready[s] = 1'b1;
        @(negedge clk);
        out_ready[s] = 1'b0;
        chk("valid_drop", 32'(out_valid[s]), 32'd0);
        chk("ready_back", 32'(in_ready[s]), 32'd1);
        chk("result_kept", 32'(out_result[s]), 32'(e.res));
    endtask

    initial begin
        t_in[0] = 32'h0000_0080; t_out[0] = 16'h0001; t_sat[0] = 1'b0;
        t_in[1] = 32'hFFFF_FF80; t_out[1] = 16'h0000; t_sat[1] = 1'b0;
        t_in[2] = 32'hFFFF_FF7F; t_out[2] = 16'hFFFF; t_sat[2] = 1'b0;
        t_in[3] = 32'h0000_007F; t_out[3] = 16'h0000; t_sat[3] = 1'b0;
        t_in[4] = 32'h0100_0000; t_out[4] = 16'h7FFF; t_sat[4] = 1'b1;
        t_in[5] = 32'hFF00_0000; t_out[5] = 16'h8000; t_sat[5] = 1'b1;
        t_in[6] = 32'hFF80_0000; t_out[6] = 16'h8000; t_sat[6] = 1'b0;

        for (int s = 0; s < 2; s++) begin
            rst[s]        = 1'b1;
            in_valid[s]   = 1'b0;
            in_product[s] = '0;
            in_last[s]    = 1'b0;
            out_ready[s]  = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready[0]), 32'd0);
        chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("rst_out_result", 32'(out_result[0]), 32'd0);
        chk("rst_out_sat", 32'(out_sat[0]), 32'd0);
        chk("rst_out_count", 32'(out_count[0]), 32'd0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        chk("post_rst_ready0", 32'(in_ready[0]), 32'd1);
        chk("post_rst_ready1", 32'(in_ready[1]), 32'd1);

        pk.delete();
        pk.push_back(32'h0002_0000);
        send(0, pk, 1'b1, 1'b1, 16'h0200, 1'b0);
        collect(0, 1);

        pk.delete();
        pk.push_back(32'h0001_0000);
        pk.push_back(32'h0002_0000);
        pk.push_back(32'hFFFF_0000);
        send(0, pk, 1'b1, 1'b1, 16'h0200, 1'b0);
        chk("b2b_stalls", stalls, 0);
        collect(0, 1);

        for (int i = 0; i < 7; i++) begin
            pk.delete();
            pk.push_back(t_in[i]);
            send(0, pk, 1'b1, 1'b1, t_out[i], t_sat[i]);
            collect(0, 1);
        end

        pk.delete();
        pk.push_back(32'h0003_0000);
        send(0, pk, 1'b1, 1'b1, 16'h0300, 1'b0);
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_last[0]  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_product[0] = $urandom;
            chk("bp_valid", 32'(out_valid[0]), 32'd1);
            chk("bp_result", 32'(out_result[0]), 32'h0300);
            chk("bp_count", 32'(out_count[0]), 32'd1);
            chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
            @(negedge clk);
        end
        in_valid[0] = 1'b0;
        in_last[0]  = 1'b0;
        collect(0, 0);
        pk.delete();
        pk.push_back(32'h0000_0100);
        send(0, pk, 1'b1, 1'b1, 16'h0001, 1'b0);
        collect(0, 1);

        pk.delete();
        pk.push_back(32'h7FFF_FFFF);
        pk.push_back(32'h7FFF_FFFF);
        pk.push_back(32'h7FFF_FFFF);
        send(1, pk, 1'b1, 1'b1, 16'h7FFF, 1'b1);
        collect(1, 1);

        pk.delete();
        pk.push_back(32'h0001_0000);
        pk.push_back(32'h0001_0000);
        send(1, pk, 1'b0, 1'b0, 16'h0000, 1'b0);
        rst[1] = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(out_valid[1]), 32'd0);
        chk("rst_mid_ready", 32'(in_ready[1]), 32'd0);
        @(negedge clk);
        rst[1] = 1'b0;
        @(negedge clk);

        pk.delete();
        pk.push_back(32'h0005_0000);
        send(1, pk, 1'b1, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        chk("pre_rst_valid", 32'(out_valid[1]), 32'd1);
        rst[1] = 1'b1;
        #1;
        chk("rst_out_valid1", 32'(out_valid[1]), 32'd0);
        chk("rst_out_ready1", 32'(in_ready[1]), 32'd0);
        @(negedge clk);
        rst[1] = 1'b0;
        @(negedge clk);
        chk("rel_in_ready1", 32'(in_ready[1]), 32'd1);

        pk.delete();
        pk.push_back(32'h0001_0000);
        send(1, pk, 1'b1, 1'b1, 16'h0100, 1'b0);
        collect(1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fixed_point_mac_accumulator.md
Name: fixed_point_mac_accumulator

Overview:
- Streaming accumulate/requantize stage directly downstream of fixed_point_multiplication.
- Consumes a packet of signed Q(N1+N2).(M1+M2) products, one per beat under valid/ready, and sums them in a guard-bit accumulator.
- On the beat flagged last, rounds and saturates the sum to signed Q(N_OUT).(M_OUT), then presents it on a valid/ready output port.
- Used for dot products and FIR taps built from the multiplier.

Parameters:
- N1, 8: integer bits of multiplier operand a
- N2, 8: integer bits of multiplier operand b
- M1, 8: fraction bits of operand a
- M2, 8: fraction bits of operand b
- G, 8: accumulator guard bits, minimum 1
- N_OUT, 8: integer bits of the output, sign bit included
- M_OUT, 8: fraction bits of the output; must satisfy M_OUT < M1+M2
- CW, 8: width of the beat counter

Derived widths:
- PW = N1+N2+M1+M2, product width
- AW = PW+G, accumulator width
- OW = N_OUT+M_OUT, output width
- SH = M1+M2-M_OUT, right-shift amount

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  product beat valid
- in_ready  out  1  block can accept a beat
- in_product  in  PW  signed two's-complement product
- in_last  in  1  beat is the final one of the packet
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_result  out  OW  signed rounded, saturated sum
- out_sat  out  1  accumulator clamped or output saturated
- out_count  out  CW  number of beats in the packet

Behaviour:
Reset:
- Asynchronous reset to state ACCUM.
- acc=0, cnt=0, ovf=0, out_valid=0, out_result=0, out_sat=0, out_count=0.
- in_ready is forced 0 while rst is high.

FSM:
- ACCUM -> ROUND -> OUTPUT -> ACCUM.
- in_ready=1 only in ACCUM (with rst low). out_valid=1 only in OUTPUT.

ACCUM:
- A beat is accepted when in_valid&in_ready.
- On acceptance: acc <= acc + sign_extend(in_product). cnt increments and saturates at 2^CW-1.
- The add is saturating. On signed overflow, acc clamps to +(2^(AW-1)-1) or -2^(AW-1) and the sticky ovf is set.
- If in_last is set on the accepted beat, that beat is included and the next state is ROUND.
- in_last with in_valid low is ignored.
- An empty packet is not possible. in_last on the first beat gives a one-beat result.

ROUND (exactly one cycle):
- r = (acc + 2^(SH-1)) >>> SH, arithmetic shift, computed at AW+1 bits.
- This is round-half-up, ties toward +inf.
- If r > 2^(OW-1)-1, output 0x7FFF (OW=16). If r < -2^(OW-1), output 0x8000. Either case sets sat.
- Registers out_result, out_sat = ovf|sat, and out_count = cnt. Next state is OUTPUT.

OUTPUT:
- out_valid=1. out_result, out_sat and out_count are held stable until out_ready.
- Input beats are not accepted; in_product is ignored.
- On out_valid&out_ready: acc, cnt and ovf clear, and the state returns to ACCUM.
- in_ready rises in the following cycle. There is no same-cycle pass-through.
- out_result keeps its last value after the handshake.

Latency:
- Last beat accepted in cycle k -> out_valid high from cycle k+2.
- Minimum packet-to-packet gap is 3 cycles for single-beat packets.

Reset mid-operation:
- In any state, rst immediately returns the block to reset values. Any partial packet is discarded.

Test Plan:
- Single beat 0x0002_0000 (2.0), last=1, out_ready=1 -> out_valid in cycle k+2, out_result=0x0200, out_sat=0, out_count=1.
- Beats 0x0001_0000, 0x0002_0000, 0xFFFF_0000 (last), back-to-back -> in_ready stays 1 for all three; out_result=0x0200, out_count=3.
- Rounding, each a single-beat packet:
  - 0x0000_0080 -> 0x0001
  - 0xFFFF_FF80 -> 0x0000
  - 0xFFFF_FF7F -> 0xFFFF
  - 0x0000_007F -> 0x0000
- Output saturation:
  - 0x0100_0000 (256.0) -> 0x7FFF, out_sat=1
  - 0xFF00_0000 (-256.0) -> 0x8000, out_sat=1
  - 0xFF80_0000 (-128.0) -> 0x8000, out_sat=0
- Backpressure: result pending, out_ready low for 5 cycles while in_valid=1 with junk data -> out_valid, out_result and out_count stable; in_ready=0; no beat absorbed. The next packet 0x0000_0100 (last) -> 0x0001.
- With G=1: three beats of 0x7FFF_FFFF -> acc clamps, out_result=0x7FFF, out_sat=1. Then reset asserted mid-packet in ACCUM and during OUTPUT -> out_valid=0 at once; after release, in_ready=1 and a fresh packet 0x0001_0000 (last) -> 0x0100, out_sat=0.
